// File: rtl/dma_desc_scheduler.sv
// Round-robin descriptor scheduler: picks one eligible queue head at a time,
// registers it toward the DMA engine, and bounds accepted-but-incomplete work.
module dma_desc_scheduler #(
   parameter int NUM_QUEUES    = 4,
   parameter int DESC_W        = 256,
   parameter int MAX_IN_FLIGHT = 32
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [NUM_QUEUES-1:0]        q_enable_i,
   input  logic [NUM_QUEUES-1:0]        q_not_empty_i,
   input  logic [NUM_QUEUES*DESC_W-1:0] q_desc_i,
   output logic [NUM_QUEUES-1:0]        q_rdack_o,
   output logic                         eng_not_empty_o,
   output logic [DESC_W-1:0]            eng_desc_o,
   output logic [$clog2(NUM_QUEUES)-1:0] eng_qid_o,
   input  logic                         eng_rdack_i,
   input  logic                         eng_done_i,
   output logic [$clog2(MAX_IN_FLIGHT+1)-1:0] in_flight_o,
   output logic                         busy_o,
   output logic                         done_underflow_o
);

   // state     | meaning
   // S_IDLE    | no descriptor held; waiting for an eligible queue and credit
   // S_PRESENT | eng_desc/eng_qid valid toward the engine until eng_rdack

   localparam int QID_W = $clog2(NUM_QUEUES);
   localparam int CNT_W = $clog2(MAX_IN_FLIGHT+1);

   typedef enum logic {S_IDLE, S_PRESENT} state_t;

   state_t              state_q;
   logic [QID_W-1:0]    rr_ptr_q;
   logic [QID_W-1:0]    eng_qid_q;
   logic [DESC_W-1:0]   eng_desc_q;
   logic [CNT_W-1:0]    in_flight_q, in_flight_d;
   logic                underflow_q, underflow_d;

   logic [NUM_QUEUES-1:0] eligible;
   logic [QID_W-1:0]    sel_idx;
   logic [QID_W-1:0]    cand;
   logic                sel_found;
   logic                grant_ok;
   logic                accept;

   assign eligible = q_enable_i & q_not_empty_i;
   assign accept   = (state_q == S_PRESENT) & eng_rdack_i;
   assign grant_ok = sel_found & (in_flight_q < CNT_W'(MAX_IN_FLIGHT));

   // Round-robin search starting just after the last accepted queue.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_QUEUES; k++) begin
         cand = QID_W'((int'(rr_ptr_q) + k) % NUM_QUEUES);
         if (!sel_found && eligible[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // Grant/present FSM; the queue is only popped on engine acceptance.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= QID_W'(NUM_QUEUES-1);
         eng_desc_q <= '0;
         eng_qid_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_ok) begin
                  eng_desc_q <= q_desc_i[int'(sel_idx)*DESC_W +: DESC_W];
                  eng_qid_q  <= sel_idx;
                  state_q    <= S_PRESENT;
               end
            end
            S_PRESENT: begin
               if (eng_rdack_i) begin
                  rr_ptr_q <= eng_qid_q;
                  state_q  <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // In-flight accounting; a completion with nothing outstanding is flagged.
   always_comb begin
      in_flight_d = in_flight_q;
      underflow_d = underflow_q;
      if (accept && !eng_done_i) begin
         in_flight_d = in_flight_q + CNT_W'(1);
      end else if (!accept && eng_done_i) begin
         if (in_flight_q == '0) underflow_d = 1'b1;
         else                   in_flight_d = in_flight_q - CNT_W'(1);
      end
   end

   // Counter and sticky error registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         in_flight_q <= '0;
         underflow_q <= 1'b0;
      end else begin
         in_flight_q <= in_flight_d;
         underflow_q <= underflow_d;
      end
   end

   assign q_rdack_o        = accept ? (NUM_QUEUES'(1) << eng_qid_q) : '0;
   assign eng_not_empty_o  = (state_q == S_PRESENT);
   assign eng_desc_o       = eng_desc_q;
   assign eng_qid_o        = eng_qid_q;
   assign in_flight_o      = in_flight_q;
   assign busy_o           = (state_q != S_IDLE) | (in_flight_q != '0);
   assign done_underflow_o = underflow_q;

endmodule
